// File: rtl/lrc_pkg.sv
// Shared definitions for the left-right consistency checker: validity codes and
// integer-part extraction of fixed-point disparities.
package lrc_pkg;

   localparam logic [1:0] LRC_OK     = 2'b00;
   localparam logic [1:0] LRC_OCC    = 2'b10;
   localparam logic [1:0] LRC_MIS    = 2'b01;
   localparam logic [1:0] LRC_BORDER = 2'b11;

   // Callers zero-extend to 32 bits and cast the result back to their integer width.
   function automatic logic [31:0] lrc_int_part(input logic [31:0] d, input int unsigned fracW);
      return d >> fracW;
   endfunction

endpackage

// File: rtl/lrc_line_ram.sv
// Simple dual-port line buffer: one write and one registered read per clock.
// Same-address collisions return old data; the caller handles bypass.
module lrc_line_ram #(
   parameter int DEPTH = 640,
   parameter int DW    = 16,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/lr_check_stream.sv
// Left-right disparity consistency check: buffers the right-view line, compares each
// left pixel against R[x-int(dL)] and tags it with a validity code plus per-line stats.
module lr_check_stream
   import lrc_pkg::*;
#(
   parameter int DISP_W = 16,
   parameter int FRAC_W = 8,
   parameter int LINE_W = 640,
   parameter int COL_W  = 10,
   parameter int TOL_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [TOL_W-1:0]  cfg_tol,
   input  logic              cfg_zero,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              s_sol,
   input  logic              s_eol,
   input  logic [DISP_W-1:0] s_dl,
   input  logic [DISP_W-1:0] s_dr,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DISP_W-1:0] m_data,
   output logic [1:0]        m_code,
   output logic              m_eol,
   output logic [COL_W:0]    line_bad,
   output logic              line_err
);

   localparam int INT_W = DISP_W - FRAC_W;
   localparam int CMP_W = TOL_W + INT_W + 1;
   localparam int XW    = ((COL_W > INT_W) ? COL_W : INT_W) + 1;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_W - 1);

   logic              advance;
   logic              accept;
   logic [COL_W-1:0]  curCol;
   logic [TOL_W-1:0]  curTol;
   logic [INT_W-1:0]  dlInt;
   logic              border0;
   logic [COL_W-1:0]  rdAddr;
   logic [DISP_W-1:0] ramRd;

   logic [COL_W-1:0]  nxtCol_q, nxtCol_d;
   logic              full_q, full_d;
   logic [TOL_W-1:0]  tolLine_q, tolLine_d;
   logic              lineErr_q, lineErr_d;

   logic              v1_q;
   logic [DISP_W-1:0] dl1_q;
   logic [DISP_W-1:0] dr1_q;
   logic              brd1_q;
   logic              byp1_q;
   logic              eol1_q;
   logic [TOL_W-1:0]  tol1_q;

   logic              mValid_q;
   logic [DISP_W-1:0] mData_q, mData_d;
   logic [1:0]        mCode_q, mCode_d;
   logic              mEol_q;

   logic [DISP_W-1:0] rdSel;
   logic [INT_W-1:0]  aInt, bInt;
   logic [CMP_W-1:0]  aC, bC, diff;

   logic [COL_W:0]    badCnt_q, badCnt_d;
   logic [COL_W:0]    lineBad_q, lineBad_d;
   logic [COL_W:0]    badSum;

   assign advance = !mValid_q || m_ready;
   assign accept  = s_valid && advance;
   assign s_ready = advance;

   assign curCol  = s_sol ? '0 : nxtCol_q;
   assign curTol  = s_sol ? cfg_tol : tolLine_q;
   assign dlInt   = INT_W'(lrc_int_part(32'(s_dl), FRAC_W));
   assign border0 = XW'(dlInt) > XW'(curCol);
   assign rdAddr  = COL_W'(XW'(curCol) - XW'(dlInt));

   // Border pixels skip the read so the RAM output stays put for the pending compare.
   lrc_line_ram #(
      .DEPTH (LINE_W),
      .DW    (DISP_W),
      .AW    (COL_W)
   ) uLineRam (
      .clk     (clk),
      .we_i    (accept),
      .waddr_i (curCol),
      .wdata_i (s_dr),
      .re_i    (accept && !border0),
      .raddr_i (rdAddr),
      .rdata_o (ramRd)
   );

   always_comb begin
      nxtCol_d  = nxtCol_q;
      full_d    = full_q;
      tolLine_d = tolLine_q;
      lineErr_d = lineErr_q;
      if (accept) begin
         nxtCol_d = (curCol == LAST_COL) ? curCol : curCol + COL_W'(1);
         full_d   = (curCol == LAST_COL);
         if (s_sol) begin
            tolLine_d = cfg_tol;
         end
         if (!s_sol && full_q) begin
            lineErr_d = 1'b1;
         end
      end
   end

   // dL=0 reads the column being written this beat, so take the incoming dR instead.
   assign rdSel = byp1_q ? dr1_q : ramRd;
   assign aInt  = INT_W'(lrc_int_part(32'(dl1_q), FRAC_W));
   assign bInt  = INT_W'(lrc_int_part(32'(rdSel), FRAC_W));

   always_comb begin
      aC   = CMP_W'(aInt);
      bC   = CMP_W'(bInt);
      diff = (aC > bC) ? (aC - bC) : (bC - aC);
      if (brd1_q) begin
         mCode_d = LRC_BORDER;
      end else if (diff <= CMP_W'(tol1_q)) begin
         mCode_d = LRC_OK;
      end else if (aC < bC) begin
         mCode_d = LRC_OCC;
      end else begin
         mCode_d = LRC_MIS;
      end
      mData_d = ((mCode_d == LRC_OK) || !cfg_zero) ? dl1_q : '0;
   end

   always_comb begin
      badSum = badCnt_q;
      if ((mCode_q != LRC_OK) && !(&badCnt_q)) begin
         badSum = badCnt_q + (COL_W+1)'(1);
      end
      badCnt_d  = badCnt_q;
      lineBad_d = lineBad_q;
      if (mValid_q && m_ready) begin
         if (mEol_q) begin
            lineBad_d = badSum;
            badCnt_d  = '0;
         end else begin
            badCnt_d  = badSum;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         nxtCol_q  <= '0;
         full_q    <= 1'b0;
         tolLine_q <= '0;
         lineErr_q <= 1'b0;
         v1_q      <= 1'b0;
         dl1_q     <= '0;
         dr1_q     <= '0;
         brd1_q    <= 1'b0;
         byp1_q    <= 1'b0;
         eol1_q    <= 1'b0;
         tol1_q    <= '0;
         mValid_q  <= 1'b0;
         mData_q   <= '0;
         mCode_q   <= LRC_OK;
         mEol_q    <= 1'b0;
         badCnt_q  <= '0;
         lineBad_q <= '0;
      end else begin
         nxtCol_q  <= nxtCol_d;
         full_q    <= full_d;
         tolLine_q <= tolLine_d;
         lineErr_q <= lineErr_d;
         badCnt_q  <= badCnt_d;
         lineBad_q <= lineBad_d;
         if (advance) begin
            v1_q     <= accept;
            mValid_q <= v1_q;
            if (accept) begin
               dl1_q  <= s_dl;
               dr1_q  <= s_dr;
               brd1_q <= border0;
               byp1_q <= (dlInt == '0);
               eol1_q <= s_eol;
               tol1_q <= curTol;
            end
            if (v1_q) begin
               mData_q <= mData_d;
               mCode_q <= mCode_d;
               mEol_q  <= eol1_q;
            end
         end
      end
   end

   assign m_valid  = mValid_q;
   assign m_data   = mData_q;
   assign m_code   = mCode_q;
   assign m_eol    = mEol_q;
   assign line_bad = lineBad_q;
   assign line_err = lineErr_q;

endmodule

// File: tb/tb_lr_check_stream.sv
// Directed bench for lr_check_stream: per-scenario tasks drive lines of L/R pairs and
// compare collected outputs against hand-derived codes, data and line statistics.
module tb_lr_check_stream;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  cfg_tol = 4'd1;
   logic        cfg_zero = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        s_sol = 1'b0;
   logic        s_eol = 1'b0;
   logic [15:0] s_dl = 16'h0;
   logic [15:0] s_dr = 16'h0;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_data;
   logic [1:0]  m_code;
   logic        m_eol;
   logic [10:0] line_bad;
   logic        line_err;

   logic        randReady = 1'b0;
   int          testsRun = 0;
   int          testsFailed = 0;

   logic [15:0] qData [$];
   logic [1:0]  qCode [$];
   logic        qEol  [$];

   lr_check_stream #(
      .DISP_W (16),
      .FRAC_W (8),
      .LINE_W (640),
      .COL_W  (10),
      .TOL_W  (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cfg_tol  (cfg_tol),
      .cfg_zero (cfg_zero),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_sol    (s_sol),
      .s_eol    (s_eol),
      .s_dl     (s_dl),
      .s_dr     (s_dr),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .m_code   (m_code),
      .m_eol    (m_eol),
      .line_bad (line_bad),
      .line_err (line_err)
   );

   always #5 clk = ~clk;

   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Each output handshake is recorded on the falling edge preceding it.
   always @(negedge clk) begin
      if (rst && m_valid && m_ready) begin
         qData.push_back(m_data);
         qCode.push_back(m_code);
         qEol.push_back(m_eol);
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic clearQueues();
      qData.delete();
      qCode.delete();
      qEol.delete();
   endtask

   task automatic sendBeat(input logic [15:0] dl, input logic [15:0] dr,
                           input logic sol, input logic eol);
      logic ok;
      s_valid = 1'b1;
      s_dl    = dl;
      s_dr    = dr;
      s_sol   = sol;
      s_eol   = eol;
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         ok = s_ready;
      end
      if (!ok) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL send_timeout got s_ready=0 want 1");
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic drain(input int n, input string name);
      int cyc;
      cyc = 0;
      while (qData.size() < n && cyc < 5000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      repeat (4) @(posedge clk);
      #1;
      testsRun++;
      if (qData.size() != n) begin
         testsFailed++;
         $display("[TB] FAIL %s_count got %0d want %0d", name, qData.size(), n);
      end
   endtask

   task automatic test_reset();
      #12;
      testsRun++;
      if (m_valid !== 1'b0 || m_data !== 16'h0 || m_code !== 2'b00 || m_eol !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_outputs got v=%b d=%h c=%b e=%b want 0 0000 00 0",
                  m_valid, m_data, m_code, m_eol);
      end
      testsRun++;
      if (line_bad !== 11'd0 || line_err !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_stats got bad=%0d err=%b want 0 0", line_bad, line_err);
      end
      testsRun++;
      if (s_ready !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL reset_ready got %b want 1", s_ready);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_latency();
      cfg_tol = 4'd1;
      cfg_zero = 1'b0;
      clearQueues();
      s_valid = 1'b1;
      s_dl = 16'h0000;
      s_dr = 16'h0000;
      s_sol = 1'b1;
      s_eol = 1'b1;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      testsRun++;
      if (m_valid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL latency_1cyc got m_valid=%b want 0", m_valid);
      end
      @(posedge clk);
      #1;
      testsRun++;
      if (m_valid !== 1'b1 || m_code !== 2'b00 || m_eol !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL latency_2cyc got v=%b c=%b e=%b want 1 00 1", m_valid, m_code, m_eol);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_uniform_line();
      int badPix;
      int firstBad;
      cfg_tol = 4'd1;
      cfg_zero = 1'b0;
      clearQueues();
      for (int c = 0; c < 640; c++) begin
         sendBeat(16'h0500, 16'h0500, c == 0, c == 639);
      end
      drain(640, "uniform");
      badPix = 0;
      firstBad = -1;
      for (int c = 0; c < qData.size(); c++) begin
         if (qCode[c] !== ((c < 5) ? 2'b11 : 2'b00) || qData[c] !== 16'h0500 || qEol[c] !== (c == 639)) begin
            badPix++;
            if (firstBad < 0) firstBad = c;
         end
      end
      testsRun++;
      if (badPix != 0) begin
         testsFailed++;
         $display("[TB] FAIL uniform_pixels got %0d bad (first col %0d) want 0", badPix, firstBad);
      end
      testsRun++;
      if (qCode.size() >= 6 && (qCode[4] !== 2'b11 || qCode[5] !== 2'b00)) begin
         testsFailed++;
         $display("[TB] FAIL uniform_border_edge got %b/%b want 11/00", qCode[4], qCode[5]);
      end
      testsRun++;
      if (line_bad !== 11'd5) begin
         testsFailed++;
         $display("[TB] FAIL uniform_line_bad got %0d want 5", line_bad);
      end
   endtask

   // Columns 0, 1 and 10 are chosen so that every pixel except column 13 checks clean.
   task automatic sendPairLine(input logic [15:0] dl10, input logic [15:0] dr10,
                               input logic changeTol, input logic [3:0] lateTol);
      logic [15:0] dl;
      logic [15:0] dr;
      for (int c = 0; c < 14; c++) begin
         dl = 16'h0000;
         dr = 16'h0000;
         if (c == 0) dr = 16'h0100;
         if (c == 1) begin
            dl = 16'h0100;
            dr = 16'h0900;
         end
         if (c == 10) begin
            dl = dl10;
            dr = dr10;
         end
         if (c == 13) dl = 16'h0300;
         sendBeat(dl, dr, c == 0, c == 13);
         if (c == 0 && changeTol) cfg_tol = lateTol;
      end
   endtask

   task automatic test_occlusion();
      cfg_tol = 4'd1;
      cfg_zero = 1'b1;
      clearQueues();
      sendPairLine(16'h0900, 16'h0900, 1'b0, 4'd0);
      drain(14, "occl");
      testsRun++;
      if (qCode.size() == 14 && (qCode[13] !== 2'b10 || qData[13] !== 16'h0000 || qEol[13] !== 1'b1)) begin
         testsFailed++;
         $display("[TB] FAIL occl_pixel got c=%b d=%h e=%b want 10 0000 1", qCode[13], qData[13], qEol[13]);
      end
      testsRun++;
      if (line_bad !== 11'd1) begin
         testsFailed++;
         $display("[TB] FAIL occl_line_bad got %0d want 1", line_bad);
      end
   endtask

   task automatic test_mismatch();
      cfg_tol = 4'd1;
      cfg_zero = 1'b0;
      clearQueues();
      sendPairLine(16'h0100, 16'h0100, 1'b0, 4'd0);
      drain(14, "mis");
      testsRun++;
      if (qCode.size() == 14 && (qCode[13] !== 2'b01 || qData[13] !== 16'h0300)) begin
         testsFailed++;
         $display("[TB] FAIL mis_pixel got c=%b d=%h want 01 0300", qCode[13], qData[13]);
      end
      testsRun++;
      if (line_bad !== 11'd1) begin
         testsFailed++;
         $display("[TB] FAIL mis_line_bad got %0d want 1", line_bad);
      end
      cfg_tol = 4'd2;
      clearQueues();
      sendPairLine(16'h0100, 16'h0100, 1'b1, 4'd0);
      drain(14, "tol2");
      testsRun++;
      if (qCode.size() == 14 && (qCode[13] !== 2'b00 || qData[13] !== 16'h0300)) begin
         testsFailed++;
         $display("[TB] FAIL tol2_pixel got c=%b d=%h want 00 0300", qCode[13], qData[13]);
      end
      testsRun++;
      if (line_bad !== 11'd0) begin
         testsFailed++;
         $display("[TB] FAIL tol_latched_line_bad got %0d want 0", line_bad);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] mem [640];
      logic [15:0] expData [$];
      logic [1:0]  expCode [$];
      logic        expEol  [$];
      int          lens [3] = '{25, 1, 40};
      logic [15:0] dl;
      logic [15:0] dr;
      logic [1:0]  code;
      int          a, b, d, bad, badLast, total, errs, firstErr;
      cfg_tol = 4'd2;
      cfg_zero = 1'b1;
      clearQueues();
      randReady = 1'b1;
      total = 0;
      badLast = 0;
      for (int l = 0; l < 3; l++) begin
         bad = 0;
         for (int c = 0; c < lens[l]; c++) begin
            dl = 16'($urandom_range(0, 16'h0FFF));
            dr = 16'($urandom_range(0, 16'h0FFF));
            mem[c] = dr;
            a = int'(dl[15:8]);
            if (a > c) begin
               code = 2'b11;
            end else begin
               b = int'(mem[c - a][15:8]);
               d = (a > b) ? a - b : b - a;
               code = (d <= 2) ? 2'b00 : ((a < b) ? 2'b10 : 2'b01);
            end
            if (code != 2'b00) bad++;
            expData.push_back((code == 2'b00) ? dl : 16'h0000);
            expCode.push_back(code);
            expEol.push_back(c == lens[l] - 1);
            sendBeat(dl, dr, c == 0, c == lens[l] - 1);
            total++;
         end
         badLast = bad;
      end
      drain(total, "bp");
      randReady = 1'b0;
      errs = 0;
      firstErr = -1;
      for (int i = 0; i < total && i < qData.size(); i++) begin
         if (qData[i] !== expData[i] || qCode[i] !== expCode[i] || qEol[i] !== expEol[i]) begin
            errs++;
            if (firstErr < 0) firstErr = i;
         end
      end
      testsRun++;
      if (errs != 0) begin
         testsFailed++;
         $display("[TB] FAIL bp_stream got %0d differing beats (first %0d) want 0", errs, firstErr);
      end
      testsRun++;
      if (line_bad !== 11'(badLast)) begin
         testsFailed++;
         $display("[TB] FAIL bp_line_bad got %0d want %0d", line_bad, badLast);
      end
   endtask

   task automatic test_overflow();
      logic [15:0] dl;
      logic [15:0] dr;
      logic        sawValid;
      cfg_tol = 4'd1;
      cfg_zero = 1'b0;
      clearQueues();
      for (int i = 0; i < 641; i++) begin
         dl = (i == 640) ? 16'h0100 : 16'h0000;
         dr = (i >= 639) ? 16'h0900 : 16'h0100;
         sendBeat(dl, dr, i == 0, 1'b0);
         if (i == 639) begin
            testsRun++;
            if (line_err !== 1'b0) begin
               testsFailed++;
               $display("[TB] FAIL ovf_err_early got %b want 0", line_err);
            end
         end
      end
      testsRun++;
      if (line_err !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL ovf_err_set got %b want 1", line_err);
      end
      drain(641, "ovf");
      testsRun++;
      if (qCode.size() == 641 && (qCode[639] !== 2'b10 || qCode[640] !== 2'b00)) begin
         testsFailed++;
         $display("[TB] FAIL ovf_saturate got %b/%b want 10/00", qCode[639], qCode[640]);
      end
      sendBeat(16'h0000, 16'h0000, 1'b1, 1'b0);
      rst = 1'b0;
      #3;
      testsRun++;
      if (line_err !== 1'b0 || m_valid !== 1'b0 || line_bad !== 11'd0) begin
         testsFailed++;
         $display("[TB] FAIL ovf_reset got err=%b v=%b bad=%0d want 0 0 0", line_err, m_valid, line_bad);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      sawValid = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (m_valid) sawValid = 1'b1;
      end
      testsRun++;
      if (sawValid !== 1'b0 || qData.size() != 641) begin
         testsFailed++;
         $display("[TB] FAIL ovf_flush got valid=%b outputs=%0d want 0 641", sawValid, qData.size());
      end
   endtask

   task automatic test_bypass();
      cfg_tol = 4'd1;
      cfg_zero = 1'b1;
      clearQueues();
      sendBeat(16'h0900, 16'h0900, 1'b1, 1'b1);
      drain(1, "border1px");
      testsRun++;
      if (qCode.size() == 1 && (qCode[0] !== 2'b11 || qData[0] !== 16'h0000)) begin
         testsFailed++;
         $display("[TB] FAIL border1px got c=%b d=%h want 11 0000", qCode[0], qData[0]);
      end
      testsRun++;
      if (line_bad !== 11'd1) begin
         testsFailed++;
         $display("[TB] FAIL border1px_line_bad got %0d want 1", line_bad);
      end
      clearQueues();
      sendBeat(16'h0040, 16'h0000, 1'b1, 1'b1);
      drain(1, "bypass");
      testsRun++;
      if (qCode.size() == 1 && (qCode[0] !== 2'b00 || qData[0] !== 16'h0040 || qEol[0] !== 1'b1)) begin
         testsFailed++;
         $display("[TB] FAIL bypass_pixel got c=%b d=%h e=%b want 00 0040 1", qCode[0], qData[0], qEol[0]);
      end
      testsRun++;
      if (line_bad !== 11'd0) begin
         testsFailed++;
         $display("[TB] FAIL bypass_line_bad got %0d want 0", line_bad);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_uniform_line();
      test_occlusion();
      test_mismatch();
      test_backpressure();
      test_overflow();
      test_bypass();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
